// File: rtl/dpe_pkg.sv
// dpe_pkg: shared types, constants and helpers for the dot-product engine
package dpe_pkg;
   typedef enum logic [2:0] {S_IDLE, S_READ, S_DRAIN, S_REDUCE, S_DONE} state_t;
   localparam int RD_LAT = 2;
   function automatic int tree_depth(input int lanes);
      return $clog2(lanes);
   endfunction
endpackage

// File: rtl/dpe_adder_tree.sv
// dpe_adder_tree: pipelined registered pairwise reduction of LANES accumulators
module dpe_adder_tree
   import dpe_pkg::*;
#(
   parameter int LANES = 8,
   parameter int ACC_W = 32
) (
   input  logic             i_clk,
   input  logic             i_resetn,
   input  logic             i_valid,
   input  logic [ACC_W-1:0] i_data [LANES],
   output logic             o_valid,
   output logic [ACC_W-1:0] o_sum
);
   localparam int D = tree_depth(LANES);
   logic [ACC_W-1:0] r_lvl [D][LANES/2];
   logic [D-1:0]     r_vld;
   // Each stage halves the operand count; valid travels alongside the data
   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         r_vld <= '0;
         for (int s = 0; s < D; s++)
            for (int i = 0; i < LANES/2; i++) r_lvl[s][i] <= '0;
      end else begin
         r_vld[0] <= i_valid;
         for (int s = 1; s < D; s++) r_vld[s] <= r_vld[s-1];
         for (int i = 0; i < LANES/2; i++) r_lvl[0][i] <= i_data[2*i] + i_data[2*i+1];
         for (int s = 1; s < D; s++)
            for (int i = 0; i < (LANES >> (s+1)); i++)
               r_lvl[s][i] <= r_lvl[s-1][2*i] + r_lvl[s-1][2*i+1];
      end
   end
   assign o_valid = r_vld[D-1];
   assign o_sum   = r_lvl[D-1][0];
endmodule

// File: rtl/dot_product_engine.sv
// dot_product_engine: banked-BRAM int8 dot product with zero points, LANES MACs and a tree reduction
module dot_product_engine
   import dpe_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ZP_W   = 9,
   parameter int ACC_W  = 32,
   parameter int N_MAX  = 256,
   parameter int LANES  = 8,
   parameter int ADDR_W = $clog2(N_MAX)
) (
   input  logic                     i_clk,
   input  logic                     i_resetn,
   input  logic                     i_wr_en,
   input  logic                     i_wr_sel,
   input  logic [ADDR_W-1:0]        i_wr_addr,
   input  logic signed [DATA_W-1:0] i_wr_data,
   input  logic                     i_start,
   input  logic [ADDR_W:0]          i_len,
   input  logic signed [ZP_W-1:0]   i_zp_a,
   input  logic signed [ZP_W-1:0]   i_zp_b,
   output logic                     o_busy,
   output logic                     o_done,
   output logic                     o_len_err,
   output logic [ACC_W-1:0]         o_result
);
   localparam int LB    = $clog2(LANES);
   localparam int DEPTH = N_MAX / LANES;
   localparam int RW    = ADDR_W - LB;
   localparam int PW    = DATA_W + 2;
   localparam int D     = tree_depth(LANES);
   localparam logic [ADDR_W:0] NMAX_L = N_MAX[ADDR_W:0];

   if (ACC_W < 2*(DATA_W+2) + $clog2(N_MAX)) begin : g_acc_chk
      $error("ACC_W too narrow for DATA_W/N_MAX");
   end
   if (N_MAX % LANES != 0) begin : g_nmax_chk
      $error("N_MAX must be a multiple of LANES");
   end
   if (LANES < 2 || (LANES & (LANES-1)) != 0) begin : g_lanes_chk
      $error("LANES must be a power of two >= 2");
   end

   state_t                 r_state;
   logic [ADDR_W:0]        r_len;
   logic                   r_over;
   logic signed [ZP_W-1:0] r_zp_a, r_zp_b;
   logic [RW-1:0]          r_row, r_last;
   logic [7:0]             r_cnt;
   logic                   r_v1, r_v2;
   logic                   r_busy, r_done, r_len_err;
   logic [ACC_W-1:0]       r_result;
   logic                   w_accept, w_we, w_tree_v;
   logic [ADDR_W:0]        w_lenc, w_lm1;
   logic [LB-1:0]          w_wbank;
   logic [RW-1:0]          w_wrow, w_last;
   logic [ACC_W-1:0]       w_acc [LANES];
   logic [ACC_W-1:0]       w_tree_sum;

   assign w_accept = i_start && (r_state == S_IDLE);
   assign w_we     = i_wr_en && (r_state == S_IDLE);
   assign w_lenc   = (i_len > NMAX_L) ? NMAX_L : i_len;
   assign w_lm1    = w_lenc - 1'b1;
   assign w_last   = RW'(w_lm1 >> LB);
   assign w_wbank  = i_wr_addr[LB-1:0];
   assign w_wrow   = i_wr_addr[ADDR_W-1:LB];

   for (genvar j = 0; j < LANES; j++) begin : g_lane
      logic signed [DATA_W-1:0] r_mem_a [DEPTH];
      logic signed [DATA_W-1:0] r_mem_b [DEPTH];
      logic signed [DATA_W-1:0] r_rd_a, r_rd_b;
      logic                     r_m1;
      logic signed [ACC_W-1:0]  r_prod, r_acc;
      logic                     w_hit;
      logic signed [PW-1:0]     w_a, w_b;
      logic signed [2*PW-1:0]   w_p;
      assign w_hit = w_we && (w_wbank == LB'(j));
      assign w_a   = PW'(r_rd_a) + PW'(r_zp_a);
      assign w_b   = PW'(r_rd_b) + PW'(r_zp_b);
      assign w_p   = w_a * w_b;
      // Bank write port and registered read of the row being issued
      always_ff @(posedge i_clk) begin
         if (w_hit && !i_wr_sel) r_mem_a[w_wrow] <= i_wr_data;
         if (w_hit && i_wr_sel) r_mem_b[w_wrow] <= i_wr_data;
         r_rd_a <= r_mem_a[r_row];
         r_rd_b <= r_mem_b[r_row];
      end
      // Masked product register, then accumulate only rows that were really issued
      always_ff @(posedge i_clk or negedge i_resetn) begin
         if (!i_resetn) begin
            r_m1   <= 1'b0;
            r_prod <= '0;
            r_acc  <= '0;
         end else begin
            r_m1   <= ({1'b0, r_row, LB'(j)} < r_len);
            r_prod <= r_m1 ? ACC_W'(w_p) : '0;
            r_acc  <= w_accept ? '0 : r_v2 ? r_acc + r_prod : r_acc;
         end
      end
      assign w_acc[j] = r_acc;
   end

   // Read-valid pipeline matching BRAM latency and the product register
   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         r_v1 <= 1'b0;
         r_v2 <= 1'b0;
      end else begin
         r_v1 <= (r_state == S_READ);
         r_v2 <= r_v1;
      end
   end

   dpe_adder_tree #(.LANES(LANES), .ACC_W(ACC_W)) u_tree (
      .i_clk    (i_clk),
      .i_resetn (i_resetn),
      .i_valid  ((r_state == S_REDUCE) && (r_cnt == 8'd0)),
      .i_data   (w_acc),
      .o_valid  (w_tree_v),
      .o_sum    (w_tree_sum)
   );

   // Control FSM with registered status and result outputs
   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         r_state   <= S_IDLE;
         r_len     <= '0;
         r_over    <= 1'b0;
         r_zp_a    <= '0;
         r_zp_b    <= '0;
         r_row     <= '0;
         r_last    <= '0;
         r_cnt     <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_len_err <= 1'b0;
         r_result  <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: if (i_start) begin
               r_len     <= w_lenc;
               r_over    <= (i_len > NMAX_L);
               r_zp_a    <= i_zp_a;
               r_zp_b    <= i_zp_b;
               r_last    <= w_last;
               r_row     <= '0;
               r_cnt     <= '0;
               r_result  <= '0;
               r_len_err <= 1'b0;
               r_busy    <= 1'b1;
               r_state   <= (w_lenc == '0) ? S_DONE : S_READ;
            end
            S_READ: begin
               r_row <= r_row + 1'b1;
               if (r_row == r_last) r_state <= S_DRAIN;
            end
            S_DRAIN: begin
               r_cnt <= (r_cnt == 8'(RD_LAT-1)) ? 8'd0 : r_cnt + 8'd1;
               if (r_cnt == 8'(RD_LAT-1)) r_state <= S_REDUCE;
            end
            S_REDUCE: begin
               r_cnt <= (r_cnt == 8'(D-1)) ? 8'd0 : r_cnt + 8'd1;
               if (r_cnt == 8'(D-1)) r_state <= S_DONE;
            end
            S_DONE: begin
               r_state   <= S_IDLE;
               r_busy    <= 1'b0;
               r_done    <= 1'b1;
               r_len_err <= r_over;
               if (w_tree_v) r_result <= w_tree_sum;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_busy    = r_busy;
   assign o_done    = r_done;
   assign o_len_err = r_len_err;
   assign o_result  = r_result;
endmodule

// File: tb/tb_dot_product_engine.sv
// tb_dot_product_engine: table vectors, corner sequences and random runs against an arithmetic model
module tb_dot_product_engine;
   logic              i_clk = 1'b0;
   logic              i_resetn = 1'b0;
   logic              i_wr_en = 1'b0;
   logic              i_wr_sel = 1'b0;
   logic [7:0]        i_wr_addr = '0;
   logic signed [7:0] i_wr_data = '0;
   logic              i_start = 1'b0;
   logic [8:0]        i_len = '0;
   logic signed [8:0] i_zp_a = '0;
   logic signed [8:0] i_zp_b = '0;
   logic              o_busy, o_done, o_len_err;
   logic [31:0]       o_result;

   always #5 i_clk = ~i_clk;

   dot_product_engine dut (
      .i_clk(i_clk), .i_resetn(i_resetn), .i_wr_en(i_wr_en), .i_wr_sel(i_wr_sel),
      .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data), .i_start(i_start), .i_len(i_len),
      .i_zp_a(i_zp_a), .i_zp_b(i_zp_b), .o_busy(o_busy), .o_done(o_done),
      .o_len_err(o_len_err), .o_result(o_result)
   );

   typedef struct {
      int          pat;
      int          len;
      int          zpa;
      int          zpb;
      logic [31:0] exp;
      bit          lerr;
   } vec_t;

   int n_pass = 0;
   int n_tot  = 0;
   int ra [256];
   int rb [256];

   task automatic chk(input string name, input longint got, input longint exp);
      n_tot++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, got, exp);
   endtask

   function automatic logic [31:0] model(input int len, input int zpa, input int zpb);
      longint s = 0;
      int lc = (len > 256) ? 256 : len;
      for (int k = 0; k < lc; k++) s += longint'(ra[k] + zpa) * longint'(rb[k] + zpb);
      return s[31:0];
   endfunction

   function automatic int exp_lat(input int len);
      int lc = (len > 256) ? 256 : len;
      return (lc == 0) ? 1 : (lc + 7) / 8 + 3 + $clog2(8);
   endfunction

   task automatic load();
      for (int k = 0; k < 512; k++) begin
         int idx = k % 256;
         @(negedge i_clk);
         i_wr_en   = 1'b1;
         i_wr_sel  = (k >= 256);
         i_wr_addr = 8'(idx);
         i_wr_data = 8'((k >= 256) ? rb[idx] : ra[idx]);
      end
      @(negedge i_clk);
      i_wr_en = 1'b0;
   endtask

   task automatic set_pat(input int p);
      for (int k = 0; k < 256; k++) begin
         ra[k] = (p == 0) ? ((k < 70) ? k + 1 : 0) : (p == 1) ? 1 : -128;
         rb[k] = ra[k];
      end
      load();
   endtask

   task automatic run(input int len, input int zpa, input int zpb, input bit noise,
                      output logic [31:0] res, output logic lerr, output int lat);
      @(negedge i_clk);
      i_start = 1'b1;
      i_len   = 9'(len);
      i_zp_a  = 9'(zpa);
      i_zp_b  = 9'(zpb);
      @(posedge i_clk);
      #1;
      i_start = 1'b0;
      chk("busy_on", o_busy, 1);
      lat = 0;
      while (lat < 200) begin
         if (noise && lat < 10) begin
            i_start   = 1'b1;
            i_len     = 9'd5;
            i_wr_en   = 1'b1;
            i_wr_sel  = lat[0];
            i_wr_addr = 8'(lat);
            i_wr_data = 8'sd99;
         end else begin
            i_start = 1'b0;
            i_wr_en = 1'b0;
         end
         @(posedge i_clk);
         #1;
         lat++;
         if (o_done) break;
      end
      i_start = 1'b0;
      i_wr_en = 1'b0;
      if (lat >= 200) chk("done_timeout", 0, 1);
      res  = o_result;
      lerr = o_len_err;
      @(posedge i_clk);
      #1;
      chk("done_pulse", o_done, 0);
      chk("busy_off", o_busy, 0);
      chk("result_hold", o_result, res);
   endtask

   vec_t        tbl [7];
   logic [31:0] res;
   logic        lerr;
   int          lat;
   int          cur_pat;

   initial begin
      tbl[0] = '{0, 70, 0, 0, 32'd116795, 1'b0};
      tbl[1] = '{1, 3, 0, 0, 32'd3, 1'b0};
      tbl[2] = '{1, 9, 0, 0, 32'd9, 1'b0};
      tbl[3] = '{1, 0, 0, 0, 32'd0, 1'b0};
      tbl[4] = '{1, 300, 0, 0, 32'd256, 1'b1};
      tbl[5] = '{2, 256, 0, 0, 32'd4194304, 1'b0};
      tbl[6] = '{2, 256, 128, 0, 32'd0, 1'b0};

      repeat (3) @(posedge i_clk);
      #1;
      chk("rst_busy", o_busy, 0);
      chk("rst_done", o_done, 0);
      chk("rst_len_err", o_len_err, 0);
      chk("rst_result", o_result, 0);
      @(negedge i_clk);
      i_resetn = 1'b1;

      cur_pat = -1;
      for (int v = 0; v < 7; v++) begin
         if (tbl[v].pat != cur_pat) begin
            set_pat(tbl[v].pat);
            cur_pat = tbl[v].pat;
         end
         run(tbl[v].len, tbl[v].zpa, tbl[v].zpb, 1'b0, res, lerr, lat);
         chk($sformatf("tbl%0d_result", v), res, tbl[v].exp);
         chk($sformatf("tbl%0d_len_err", v), lerr, tbl[v].lerr);
         chk($sformatf("tbl%0d_latency", v), lat, exp_lat(tbl[v].len));
      end

      // reset asserted in the middle of READ, then a clean rerun
      set_pat(0);
      run(300, 0, 0, 1'b0, res, lerr, lat);
      @(negedge i_clk);
      i_start = 1'b1;
      i_len   = 9'd70;
      i_zp_a  = '0;
      i_zp_b  = '0;
      @(posedge i_clk);
      #1;
      i_start = 1'b0;
      repeat (4) @(posedge i_clk);
      #1;
      i_resetn = 1'b0;
      #1;
      chk("midrst_busy", o_busy, 0);
      chk("midrst_done", o_done, 0);
      chk("midrst_result", o_result, 0);
      chk("midrst_len_err", o_len_err, 0);
      @(negedge i_clk);
      i_resetn = 1'b1;
      run(70, 0, 0, 1'b0, res, lerr, lat);
      chk("midrst_rerun_result", res, 32'd116795);
      chk("midrst_rerun_latency", lat, 15);

      // start and writes while busy must be ignored
      run(70, 0, 0, 1'b1, res, lerr, lat);
      chk("noise_result", res, 32'd116795);
      chk("noise_latency", lat, 15);
      run(70, 0, 0, 1'b0, res, lerr, lat);
      chk("readback_70", res, 32'd116795);
      run(1, 0, 0, 1'b0, res, lerr, lat);
      chk("readback_1", res, 32'd1);

      // random contents, lengths and zero points against the model
      for (int t = 0; t < 12; t++) begin
         int len, zpa, zpb;
         for (int k = 0; k < 256; k++) begin
            ra[k] = int'($urandom_range(0, 255)) - 128;
            rb[k] = int'($urandom_range(0, 255)) - 128;
         end
         load();
         len = int'($urandom_range(0, 300));
         zpa = int'($urandom_range(0, 511)) - 256;
         zpb = int'($urandom_range(0, 511)) - 256;
         run(len, zpa, zpb, 1'b0, res, lerr, lat);
         chk($sformatf("rnd%0d_result", t), res, model(len, zpa, zpb));
         chk($sformatf("rnd%0d_len_err", t), lerr, (len > 256) ? 1 : 0);
         chk($sformatf("rnd%0d_latency", t), lat, exp_lat(len));
      end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
